// File: rtl/snes_ctrl_pkg.sv
// Shared types and constants for the SNES controller source arbiter.
package snes_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        OWN_KB  = 2'b01,
        OWN_IR  = 2'b10,
        OWN_BTN = 2'b11
    } owner_e;

    localparam logic [1:0] MODE_AUTO = 2'b00;
    localparam logic [1:0] MODE_KB   = 2'b01;
    localparam logic [1:0] MODE_IR   = 2'b10;
    localparam logic [1:0] MODE_BTN  = 2'b11;

    localparam int DEF_HOLD_TICKS     = 2000;
    localparam int DEF_IR_STALE_TICKS = 1200;

    function automatic owner_e mode_owner(input logic [1:0] mode);
        case (mode)
            MODE_KB:  return OWN_KB;
            MODE_IR:  return OWN_IR;
            MODE_BTN: return OWN_BTN;
            default:  return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/latch_sync.sv
// Two-flop synchronizer for an asynchronous level plus a one-cycle rising-edge pulse.
module latch_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/source_arbiter.sv
// Arbitrates keyboard, IR and button-board sources onto one SNES frame snapshot.
// Define SRC_ARB_STATUS_EN to add the registered owner[1:0] status output.
module source_arbiter
    import snes_ctrl_pkg::*;
#(
    parameter int HOLD_TICKS     = DEF_HOLD_TICKS,
    parameter int IR_STALE_TICKS = DEF_IR_STALE_TICKS
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_10khz,
    input  logic       snes_latch,
    input  logic       kb_valid,
    input  logic [7:0] kb_buttons,
    input  logic       ir_valid,
    input  logic [7:0] ir_buttons,
    input  logic [7:0] btn_buttons,
    input  logic [1:0] dip,
`ifdef SRC_ARB_STATUS_EN
    output logic [1:0] owner,
`endif
    output logic [7:0] snes_data
);

    localparam int IDLE_W  = $clog2(HOLD_TICKS + 1);
    localparam int STALE_W = $clog2(IR_STALE_TICKS + 1);
    localparam logic [IDLE_W-1:0]  HOLD_MAX   = IDLE_W'(HOLD_TICKS);
    localparam logic [STALE_W-1:0] STALE_LAST = STALE_W'(IR_STALE_TICKS - 1);

    logic [7:0]         r_kb_q;
    logic [7:0]         r_ir_q;
    logic [STALE_W-1:0] r_stale_cnt;
    logic [7:0]         r_btn_meta;
    logic [7:0]         r_btn_q;
    owner_e             r_state;
    logic [IDLE_W-1:0]  r_idle_cnt;
    logic [1:0]         r_dip_prev;
    logic [7:0]         r_snes_data;

    logic       w_latch_rise;
    logic [7:0] w_owner_vec;
    logic       w_owner_act;

    latch_sync u_latch_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (snes_latch),
        .o_rise  (w_latch_rise)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_kb_q      <= 8'h00;
            r_ir_q      <= 8'h00;
            r_stale_cnt <= '0;
            r_btn_meta  <= 8'h00;
            r_btn_q     <= 8'h00;
        end else begin
            r_btn_meta <= btn_buttons;
            r_btn_q    <= r_btn_meta;
            if (kb_valid) begin
                r_kb_q <= kb_buttons;
            end
            // The stale counter parks at its last value; ir_q stays cleared until the next ir_valid.
            if (ir_valid) begin
                r_ir_q      <= ir_buttons;
                r_stale_cnt <= '0;
            end else if (tick_10khz) begin
                if (r_stale_cnt == STALE_LAST) begin
                    r_ir_q <= 8'h00;
                end else begin
                    r_stale_cnt <= r_stale_cnt + STALE_W'(1);
                end
            end
        end
    end

    // NOTE: default assignment first keeps this combinational block latch-free.
    always_comb begin
        w_owner_vec = 8'h00;
        case (r_state)
            OWN_KB:  w_owner_vec = r_kb_q;
            OWN_IR:  w_owner_vec = r_ir_q;
            OWN_BTN: w_owner_vec = r_btn_q;
            default: w_owner_vec = 8'h00;
        endcase
    end

    assign w_owner_act = |w_owner_vec;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_idle_cnt <= '0;
            r_dip_prev <= MODE_AUTO;
        end else begin
            r_dip_prev <= dip;
            if (dip != MODE_AUTO) begin
                r_state    <= mode_owner(dip);
                r_idle_cnt <= '0;
            end else if (r_dip_prev != MODE_AUTO) begin
                r_state    <= IDLE;
                r_idle_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_idle_cnt <= '0;
                        if (|r_btn_q) begin
                            r_state <= OWN_BTN;
                        end else if (|r_kb_q) begin
                            r_state <= OWN_KB;
                        end else if (|r_ir_q) begin
                            r_state <= OWN_IR;
                        end
                    end
                    default: begin
                        // Owner activity outranks expiry so a late press keeps the console.
                        if (w_owner_act) begin
                            r_idle_cnt <= '0;
                        end else if (r_idle_cnt == HOLD_MAX) begin
                            r_state    <= IDLE;
                            r_idle_cnt <= '0;
                        end else if (tick_10khz) begin
                            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    // The snapshot reads the registered owner, so a coincident state change is not yet visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snes_data <= 8'h00;
        end else if (w_latch_rise) begin
            r_snes_data <= w_owner_vec;
        end
    end

    assign snes_data = r_snes_data;

`ifdef SRC_ARB_STATUS_EN
    assign owner = r_state;
`endif

endmodule

// File: tb/tb_source_arbiter.sv
// Scoreboard bench for source_arbiter: a behavioural model predicts each frame snapshot.
module tb_source_arbiter;

    localparam int HOLD  = 2000;
    localparam int STALE = 1200;
    localparam int O_IDLE = 0;
    localparam int O_KB   = 1;
    localparam int O_IR   = 2;
    localparam int O_BTN  = 3;

    logic       clk         = 1'b0;
    logic       reset_n     = 1'b1;
    logic       tick_10khz  = 1'b0;
    logic       snes_latch  = 1'b0;
    logic       kb_valid    = 1'b0;
    logic [7:0] kb_buttons  = 8'h00;
    logic       ir_valid    = 1'b0;
    logic [7:0] ir_buttons  = 8'h00;
    logic [7:0] btn_buttons = 8'h00;
    logic [1:0] dip         = 2'b00;
    logic [7:0] snes_data;
`ifdef SRC_ARB_STATUS_EN
    logic [1:0] owner;
`endif

    source_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick_10khz  (tick_10khz),
        .snes_latch  (snes_latch),
        .kb_valid    (kb_valid),
        .kb_buttons  (kb_buttons),
        .ir_valid    (ir_valid),
        .ir_buttons  (ir_buttons),
        .btn_buttons (btn_buttons),
        .dip         (dip),
`ifdef SRC_ARB_STATUS_EN
        .owner       (owner),
`endif
        .snes_data   (snes_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle tick on every other clock.
    always @(negedge clk) tick_10khz = ~tick_10khz;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int         due;
        logic [7:0] val;
    } snap_t;

    snap_t      sb[$];
    int         m_owner    = O_IDLE;
    int         m_idle     = 0;
    int         m_ir_age   = 0;
    int         m_prev_dip = 0;
    logic [7:0] m_kb       = 8'h00;
    logic [7:0] m_ir       = 8'h00;
    logic [7:0] m_btn_s0   = 8'h00;
    logic [7:0] m_btn_s1   = 8'h00;
    logic       m_lat0     = 1'b0;
    logic       m_lat1     = 1'b0;
    logic       m_lat2     = 1'b0;

    function automatic logic [7:0] held(input int o);
        case (o)
            O_KB:    return m_kb;
            O_IR:    return m_ir;
            O_BTN:   return m_btn_s1;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_owner = O_IDLE; m_idle = 0; m_ir_age = 0; m_prev_dip = 0;
            m_kb = 8'h00; m_ir = 8'h00; m_btn_s0 = 8'h00; m_btn_s1 = 8'h00;
            m_lat0 = 1'b0; m_lat1 = 1'b0; m_lat2 = 1'b0;
            sb.delete();
        end else begin
            // Snapshot lands on the third clock after the raw latch rose, from pre-edge owner.
            if (m_lat1 && !m_lat2) sb.push_back('{cyc + 1, held(m_owner)});

            if (dip != 2'b00) begin
                case (dip)
                    2'b01:   m_owner = O_KB;
                    2'b10:   m_owner = O_IR;
                    default: m_owner = O_BTN;
                endcase
                m_idle = 0;
            end else if (m_prev_dip != 0) begin
                m_owner = O_IDLE;
                m_idle  = 0;
            end else if (m_owner == O_IDLE) begin
                if (held(O_BTN) != 0)     m_owner = O_BTN;
                else if (held(O_KB) != 0) m_owner = O_KB;
                else if (held(O_IR) != 0) m_owner = O_IR;
            end else if (held(m_owner) != 0) begin
                m_idle = 0;
            end else if (m_idle == HOLD) begin
                m_owner = O_IDLE;
                m_idle  = 0;
            end else if (tick_10khz) begin
                m_idle++;
            end

            if (kb_valid) m_kb = kb_buttons;
            if (ir_valid) begin
                m_ir     = ir_buttons;
                m_ir_age = 0;
            end else if (tick_10khz) begin
                m_ir_age++;
                if (m_ir_age >= STALE) m_ir = 8'h00;
            end
            m_btn_s1   = m_btn_s0;
            m_btn_s0   = btn_buttons;
            m_lat2     = m_lat1;
            m_lat1     = m_lat0;
            m_lat0     = snes_latch;
            m_prev_dip = int'(dip);
        end
    end

    // ---------------- monitor ----------------
    logic       mon_en   = 1'b0;
    logic [7:0] exp_snes = 8'h00;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!reset_n) exp_snes = 8'h00;
            else begin
                while (sb.size() > 0 && sb[0].due <= cyc) begin
                    exp_snes = sb[0].val;
                    void'(sb.pop_front());
                end
            end
            check("snes_data", {24'h0, snes_data}, {24'h0, exp_snes});
`ifdef SRC_ARB_STATUS_EN
            check("owner", {30'h0, owner}, m_owner);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic latch_pulse(input logic [7:0] exp_val, input string name);
        @(negedge clk); snes_latch = 1'b1;
        repeat (3) @(negedge clk);
        check(name, {24'h0, snes_data}, {24'h0, exp_val});
        snes_latch = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic kb_send(input logic [7:0] v);
        @(negedge clk); kb_valid = 1'b1; kb_buttons = v;
        @(negedge clk); kb_valid = 1'b0;
    endtask

    task automatic ir_send(input logic [7:0] v);
        @(negedge clk); ir_valid = 1'b1; ir_buttons = v;
        @(negedge clk); ir_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        check("reset_snes", {24'h0, snes_data}, 32'h0);

        // BTN beats KB when both become active together.
        @(negedge clk); btn_buttons = 8'h01;
        kb_send(8'h10);
        latch_pulse(8'h01, "req034_btn_wins");

        // Reach OWN_KB through a forced-mode round trip, then hand over to IR by timeout.
        @(negedge clk); btn_buttons = 8'h00;
        repeat (3) @(negedge clk);
        dip = 2'b01;
        @(negedge clk); dip = 2'b00;
        repeat (3) @(negedge clk);
        @(negedge clk); kb_valid = 1'b1; kb_buttons = 8'h00; ir_valid = 1'b1; ir_buttons = 8'h04;
        @(negedge clk); kb_valid = 1'b0; ir_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (1000) @(negedge clk);
            ir_send(8'h04);
            if (i == 1) latch_pulse(8'h00, "req035_not_yet");
        end
        latch_pulse(8'h04, "req035_ir_owns");

        // Single IR frame goes stale; KB waits out the hold, then takes over.
        ir_send(8'h80);
        repeat (1200) @(negedge clk);
        latch_pulse(8'h80, "req036_ir_fresh");
        repeat (1400) @(negedge clk);
        latch_pulse(8'h00, "req036_ir_stale");
        repeat (1800) @(negedge clk);
        kb_send(8'h08);
        latch_pulse(8'h00, "req021_no_preempt");
        repeat (2200) @(negedge clk);
        latch_pulse(8'h08, "req036_idle_then_kb");

        // Owner press on the expiry cycle keeps ownership (BTN would win a fresh grant).
        @(negedge clk); btn_buttons = 8'h01;
        kb_send(8'h00);
        found = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            @(negedge clk); #1;
            if (m_idle == HOLD - 1 && tick_10khz) found = 1'b1;
        end
        check("req022_reached_expiry", {31'h0, found}, 32'h1);
        kb_valid = 1'b1; kb_buttons = 8'h11;
        @(negedge clk); kb_valid = 1'b0;
        latch_pulse(8'h11, "req022_keep");

        // Latch edge coincides with forced switch away from OWN_KB.
        @(negedge clk); btn_buttons = 8'h00;
        kb_send(8'h02);
        repeat (2) @(negedge clk);
        @(negedge clk); snes_latch = 1'b1;
        @(negedge clk);
        @(negedge clk); dip = 2'b11;
        @(negedge clk);
        check("req039_pre_change", {24'h0, snes_data}, 32'h02);
        snes_latch = 1'b0;
        repeat (3) @(negedge clk);
        latch_pulse(8'h00, "req037_forced_btn_zero");
        repeat (10000) @(negedge clk);
        btn_buttons = 8'h40;
        repeat (3) @(negedge clk);
        latch_pulse(8'h40, "req037_no_timeout");

        // Back to auto, then asynchronous reset mid-ownership.
        @(negedge clk); btn_buttons = 8'h20;
        repeat (3) @(negedge clk);
        dip = 2'b00;
        repeat (3) @(negedge clk);
        latch_pulse(8'h20, "req038_setup");
        @(negedge clk); #1 reset_n = 1'b0;
        #1 check("req038_async_clear", {24'h0, snes_data}, 32'h0);
`ifdef SRC_ARB_STATUS_EN
        check("req038_owner_idle", {30'h0, owner}, 32'h0);
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        latch_pulse(8'h20, "req029_resume");

        // Reset in the middle of a latch sequence leaves no snapshot behind.
        @(negedge clk); btn_buttons = 8'h00; snes_latch = 1'b1;
        @(negedge clk); #1 reset_n = 1'b0;
        @(negedge clk); snes_latch = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("req029_no_partial", {24'h0, snes_data}, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            kb_valid   = ($urandom_range(0, 7) == 0);
            kb_buttons = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            ir_valid   = ($urandom_range(0, 15) == 0);
            ir_buttons = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 31) == 0)
                btn_buttons = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 199) == 0) dip = 2'($urandom_range(0, 3));
            else if (dip != 2'b00 && $urandom_range(0, 49) == 0) dip = 2'b00;
            if ($urandom_range(0, 3) == 0) snes_latch = ~snes_latch;
        end
        @(negedge clk);
        kb_valid = 1'b0; ir_valid = 1'b0; snes_latch = 1'b0;
        repeat (10) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/source_arbiter.md
SOURCE_ARBITER -- requirements
Module: source_arbiter

Interface
REQ-001 Parameter: HOLD_TICKS, 2000, number of idle tick_10khz ticks before the owning source releases the console (200 ms).
REQ-002 Parameter: IR_STALE_TICKS, 1200, number of ticks without ir_valid before held IR buttons clear (120 ms).
REQ-003 Port: clk, in, 1, system clock (2.08 MHz oscillator domain).
REQ-004 Port: reset_n, in, 1, reset, asynchronous, active-low.
REQ-005 Port: tick_10khz, in, 1, single-clk-cycle enable pulse from the clock divider.
REQ-006 Port: snes_latch, in, 1, console latch, asynchronous to clk.
REQ-007 Port: kb_valid, in, 1, keyboard reader data-available pulse.
REQ-008 Port: kb_buttons, in, 8, decoded keyboard buttons, active-high.
REQ-009 Port: ir_valid, in, 1, IR reader data-available pulse.
REQ-010 Port: ir_buttons, in, 8, decoded IR buttons, active-high.
REQ-011 Port: btn_buttons, in, 8, button-board level inputs, already inverted to active-high.
REQ-012 Port: dip, in, 2, mode select: 00 auto, 01 force KB, 10 force IR, 11 force BTN.
REQ-013 Port: snes_data, out, 8, frame snapshot to the SNES encoder d input.

Function
REQ-014 kb_q SHALL load kb_buttons on each clk cycle where kb_valid=1, and hold otherwise.
REQ-015 ir_q SHALL load ir_buttons on ir_valid=1 and clear to 8'h00 after IR_STALE_TICKS ticks without ir_valid.
REQ-016 btn_buttons SHALL pass through a 2-flop synchronizer before use.
REQ-017 A source SHALL be active when its held vector is nonzero.
REQ-018 FSM states SHALL be IDLE, OWN_BTN, OWN_KB, OWN_IR.
REQ-019 Auto, IDLE: next clk SHALL grant the highest-priority active source (BTN > KB > IR); with none active, stay IDLE.
REQ-020 Auto, OWN_x: owner active SHALL clear idle_cnt; owner inactive SHALL increment idle_cnt on each tick (saturating, width $clog2(HOLD_TICKS+1)); idle_cnt==HOLD_TICKS SHALL return to IDLE and clear idle_cnt.
REQ-021 Auto: non-owner activity SHALL be ignored while owned (no preemption).
REQ-022 If the owner becomes active in the same cycle the counter would expire, ownership SHALL be kept and idle_cnt cleared.
REQ-023 Forced modes SHALL enter the matching OWN_x state on the clk after dip changes, with idle_cnt cleared and no timeout.
REQ-024 A change from a forced mode to auto SHALL go to IDLE.
REQ-025 snes_latch SHALL be 2-flop synchronized and rising-edge detected; snes_data SHALL update exactly 3 clk after the raw rising edge.
REQ-026 On update, snes_data SHALL take the owner's held vector, or 8'h00 in IDLE; it SHALL hold stable between latch edges.
REQ-027 When a latch edge and a state change coincide, the snapshot SHALL use the pre-change (registered) owner.

Reset
REQ-028 On reset_n=0: state IDLE; idle_cnt, stale counter, kb_q, ir_q, synchronizers and snes_data all 0.
REQ-029 A reset mid-ownership or mid-latch SHALL abort with no partial snapshot; operation resumes on the first clk after release.

Configuration
REQ-030 With SRC_ARB_STATUS_EN defined, an extra output owner[1:0] SHALL be added (00 IDLE, 01 KB, 10 IR, 11 BTN), registered and reset to 00.
REQ-031 Without SRC_ARB_STATUS_EN, the owner port SHALL be absent and behaviour otherwise identical.

Structure
REQ-032 Package snes_ctrl_pkg SHALL hold the owner_e enum, the dip mode constants (MODE_AUTO/KB/IR/BTN), and the default HOLD_TICKS and IR_STALE_TICKS.
REQ-033 Sub-module latch_sync SHALL implement the 2-flop synchronizer and rising-edge pulse, instantiated once for snes_latch.

Verification
REQ-034 Auto; btn=8'h01 and kb_valid with 8'h10 in the same cycle; then latch -> owner BTN, snes_data=8'h01.
REQ-035 Auto, OWN_KB; kb to 8'h00, IR active 8'h04; after HOLD_TICKS ticks -> IDLE, then OWN_IR; next latch snes_data=8'h04, not earlier.
REQ-036 IR 8'h80 with ir_valid once, no repeat -> ir_q clears after 1200 ticks; a following latch gives 8'h00 and the FSM returns to IDLE after the hold expires.
REQ-037 dip=11 while OWN_KB -> OWN_BTN next clk; with btn=0, snes_data=8'h00 on latch and no timeout after 5000 ticks.
REQ-038 reset_n low mid-ownership with snes_data=8'h20 -> snes_data=8'h00 and state IDLE immediately, with no clk required.
REQ-039 Latch edge on the cycle the FSM leaves OWN_KB (kb_q=8'h02) -> snes_data=8'h02.
